// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point radix-4 FFT core: serial load, settle, snapshot, bin streaming.
// Define FFT_DIGIT_REVERSE_EN to emit bins in natural order; otherwise bins leave in core slot order.
module fft16_frame_ctrl #(
    parameter int N          = 16,
    parameter int WIDTH      = 16,
    parameter int OUTW       = 48,
    parameter int SETTLE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    output logic                    fft_load,
    output logic [3:0]              fft_addr,
    output logic signed [WIDTH-1:0] fft_xr,
    input  logic [N*OUTW-1:0]       fft_yr_flat,
    input  logic [N*OUTW-1:0]       fft_yi_flat,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUTW-1:0]  m_yr,
    output logic signed [OUTW-1:0]  m_yi,
    output logic [3:0]              m_index,
    output logic                    m_last,
    output logic                    busy,
    output logic                    frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_OUTPUT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_wcnt;
    logic [3:0]          r_rcnt;
    logic [3:0]          r_scnt;
    logic                r_fft_load;
    logic [3:0]          r_fft_addr;
    logic signed [WIDTH-1:0] r_fft_xr;
    logic [N*OUTW-1:0]   r_snap_yr;
    logic [N*OUTW-1:0]   r_snap_yi;
    logic                r_frame_done;
    logic                w_accept;
    logic                w_out_hs;
    logic [3:0]          w_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) w_next = S_LOAD;
            end
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid && r_wcnt == 4'd15) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                // First SETTLE cycle carries the final load pulse; count SETTLE_CYC beyond it.
                if (r_scnt == 4'(SETTLE_CYC)) w_next = S_CAPTURE;
            end
            S_CAPTURE: w_next = S_OUTPUT;
            S_OUTPUT: begin
                m_valid = 1'b1;
                if (m_ready && r_rcnt == 4'd15) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = s_valid & s_ready;
    assign w_out_hs = m_valid & m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= 4'd0;
            r_rcnt <= 4'd0;
            r_scnt <= 4'd0;
        end else begin
            if (w_accept) r_wcnt <= r_wcnt + 4'd1;
            if (w_out_hs) r_rcnt <= r_rcnt + 4'd1;
            if (r_state == S_SETTLE)
                r_scnt <= (r_scnt == 4'(SETTLE_CYC)) ? 4'd0 : r_scnt + 4'd1;
        end
    end

    // Load port: one registered write per accepted sample, address/data held through gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fft_load <= 1'b0;
            r_fft_addr <= 4'd0;
            r_fft_xr   <= '0;
        end else begin
            r_fft_load <= w_accept;
            if (w_accept) begin
                r_fft_addr <= r_wcnt;
                r_fft_xr   <= s_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_yr    <= '0;
            r_snap_yi    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == S_CAPTURE) begin
                r_snap_yr <= fft_yr_flat;
                r_snap_yi <= fft_yi_flat;
            end
            r_frame_done <= w_out_hs && (r_rcnt == 4'd15);
        end
    end

`ifdef FFT_DIGIT_REVERSE_EN
    assign w_slot = {r_rcnt[1:0], r_rcnt[3:2]};
`else
    assign w_slot = r_rcnt;
`endif

    assign fft_load   = r_fft_load;
    assign fft_addr   = r_fft_addr;
    assign fft_xr     = r_fft_xr;
    assign m_yr       = r_snap_yr[int'(w_slot)*OUTW +: OUTW];
    assign m_yi       = r_snap_yi[int'(w_slot)*OUTW +: OUTW];
    assign m_index    = r_rcnt;
    assign m_last     = m_valid && (r_rcnt == 4'd15);
    assign frame_done = r_frame_done;

endmodule
